adder_share_arb: RTL
====================

# adder_share_arb

Two-requester arbiter that time-shares one 16-bit adder between two clients.

- Drives the select line of two internal 16-bit 2:1 operand muxes: one for operand A, one for operand B.
- Captures the adder's sum and carry.
- Returns the result to the granted client with a one-cycle done pulse.
- Sits between the stopwatch counters/lap logic and the single adder in the AdderModule datapath.
- Arbitration is round-robin by default; fixed priority is a compile-time option.

## Interface

Parameters:
- WIDTH, 16, operand and result width. Must match the 16-bit mux width.

Ports:
- clk  in  1  single clock. All state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0  in  1  client 0 request, level. Hold high until done0.
- a0, b0  in  WIDTH  client 0 operands. Hold stable from req0 high through done0.
- req1  in  1  client 1 request, level.
- a1, b1  in  WIDTH  client 1 operands. Same hold rule as client 0.
- add_a, add_b  out  WIDTH  muxed operands to the shared adder. Combinational from sel.
- add_s  in  WIDTH  shared adder sum. Combinational, valid in the same cycle.
- add_co  in  1  shared adder carry-out.
- sel  out  1  mux select. 0 selects client 0, 1 selects client 1. Registered.
- gnt0, gnt1  out  1  one-hot grant, held from EXEC through RESP.
- done0, done1  out  1  one-cycle completion pulse to the granted client.
- res  out  WIDTH  registered sum. Valid while doneX is high; holds its value afterwards.
- res_co  out  1  registered carry-out, same timing as res.
- busy  out  1  high in EXEC and RESP.

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE: sample req0 and req1.
  - No request: stay in IDLE.
  - Otherwise: choose a winner, register sel and the matching gntX, then go to EXEC.
- EXEC: add_a/add_b present the winner's operands.
  - On the clock edge, capture res <= add_s and res_co <= add_co.
  - Go to RESP.
- RESP: assert doneX for the winner for exactly one cycle.
  - Update the round-robin pointer: last <= sel.
  - Go to IDLE. gntX and busy drop on entering IDLE.
- Round-robin:
  - If only one request is present, it wins.
  - If both are present, the client that is not `last` wins.
  - After reset, last = 1, so client 0 wins the first simultaneous contention.
- Request handling:
  - Requests are sampled only in IDLE.
  - A requester that drops req during EXEC or RESP does not abort the operation; done still pulses.
  - A requester that keeps req high after its done re-enters arbitration in the next IDLE cycle.
  - In that case, if the other client is also requesting, the other client wins.
- Arithmetic: res = (a + b) mod 2^WIDTH, and res_co is the carry out of bit WIDTH-1.
  - Example: 0xFFFF + 0x0001 gives res = 0x0000, res_co = 1.
- Operand muxes: two WIDTH-bit 2:1 mux instances, both driven by sel. No other logic sits in the operand path.

## Timing

- Reset values (rst_n low at a rising edge): state = IDLE, sel = 0, gnt0 = gnt1 = 0, done0 = done1 = 0, res = 0, res_co = 0, busy = 0, last = 1.
  - During reset, add_a = a0 and add_b = b0, because sel = 0.
- Reset mid-operation: asserting rst_n low in EXEC or RESP aborts the operation.
  - All outputs take their reset values on that edge.
  - No done pulse is issued.
- Latency: a request seen high in IDLE cycle N gives:
  - gnt/sel valid in cycle N+1 (EXEC),
  - doneX and res valid in cycle N+2 (RESP),
  - IDLE again in cycle N+3.
- Throughput: one operation per 3 cycles.
- Back-to-back alternation with both requests held high: done0, done1, done0, … spaced 3 cycles apart.
- The adder path must settle within one cycle: sel register → mux → adder → res register.

## Configuration

- ADD_SHARE_FIXED_PRIO_EN
  - Defined: fixed priority. Client 0 always wins when both request. The `last` register is not implemented. Client 1 may starve.
  - Undefined (default): round-robin as specified above.

## Test plan

- Reset: hold rst_n = 0 for 2 cycles with random inputs → all outputs at reset values, busy = 0, no doneX pulse.
- Single client: req0 = 1, a0 = 0x1234, b0 = 0x0FF0 → gnt0 = 1 and sel = 0 at N+1; done0 = 1, res = 0x2224, res_co = 0 at N+2; busy = 0 at N+3.
- Overflow: req1 = 1, a1 = 0xFFFF, b1 = 0x0001 → sel = 1, done1 at N+2, res = 0x0000, res_co = 1.
- Contention: req0 = req1 = 1 held for 12 cycles →
  - round-robin build: done0 at 2, done1 at 5, done0 at 8, done1 at 11;
  - fixed-priority build: done0 at 2, 5, 8, 11 and done1 never.
- Withdrawal: req0 dropped in EXEC → done0 still pulses at N+2 with the correct sum; no second grant follows.
- Reset mid-op: rst_n = 0 during RESP → done is cleared, state = IDLE; next request is served with normal N+2 latency.

Source files
------------

// File: rtl/adder_share_arb.sv
// Time-shares one WIDTH-bit adder between two level-request clients; grant at N+1, done/res at N+2, idle at N+3.
// Round-robin by default, fixed priority (client 0 wins) when ADD_SHARE_FIXED_PRIO_EN is defined.

module adder_share_mux #(
  parameter int WIDTH = 16
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

module adder_share_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co,
  output logic             sel,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             res_co,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   win;

  adder_share_mux #(.WIDTH(WIDTH)) u_mux_a (
    .sel (sel),
    .d0  (a0),
    .d1  (a1),
    .y   (add_a)
  );

  adder_share_mux #(.WIDTH(WIDTH)) u_mux_b (
    .sel (sel),
    .d0  (b0),
    .d1  (b1),
    .y   (add_b)
  );

`ifdef ADD_SHARE_FIXED_PRIO_EN
  assign win = req1 & ~req0;
`else
  logic last;
  // Under contention the client that was not served last wins.
  assign win = req1 & (~req0 | ~last);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= 1'b0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      res    <= '0;
      res_co <= 1'b0;
      busy   <= 1'b0;
`ifndef ADD_SHARE_FIXED_PRIO_EN
      last   <= 1'b1;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel   <= win;
            gnt0  <= ~win;
            gnt1  <= win;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          res    <= add_s;
          res_co <= add_co;
          done0  <= gnt0;
          done1  <= gnt1;
          state  <= RESP;
        end
        RESP: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
`ifndef ADD_SHARE_FIXED_PRIO_EN
          last  <= sel;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
